// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
//   Shared types for the stack-pointer sequencer.
//   - op_e     : request opcode driven by the control unit on req_op
//   - state_e  : sequencer FSM states
//   - default stack geometry (empty-stack SP and lowest legal SP)
//   - drives_mem(): which states own the memory bus
// -----------------------------------------------------------------------------
package stack_pkg;

    // Request opcodes. 2'b11 is deliberately left undefined: the sequencer
    // accepts it and retires it next cycle without side effects.
    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_LOAD = 2'b10
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PUSH_DEC = 3'd1,
        S_PUSH_WR  = 3'd2,
        S_POP_RD   = 3'd3,
        S_POP_INC  = 3'd4,
        S_LOAD     = 3'd5
    } state_e;

    // Empty stack sits at the top; the stack grows toward lower addresses.
    localparam logic [31:0] DEFAULT_STACK_BASE  = 32'h0001_0000;
    localparam logic [31:0] DEFAULT_STACK_LIMIT = 32'h0000_F000;

    // States in which the sequencer owns the memory bus and SP drives the
    // address bus.
    function automatic logic drives_mem(input state_e s);
        return (s == S_PUSH_WR) || (s == S_POP_RD);
    endfunction

endpackage

// File: rtl/stack_seq.sv
// -----------------------------------------------------------------------------
// stack_seq
//   Stack-pointer sequencer. Turns PUSH / POP / LOAD requests into SP control
//   strobes and single-word memory accesses. The SP register itself lives next
//   to this block at CPU top level: SP drives the address bus, this block
//   drives the data bus and strobes.
//
//   Optional feature macro: STACK_BOUNDS_CHECK_EN
//     defined   : PUSH at STACK_LIMIT and POP at STACK_BASE retire immediately
//                 with done+fault and no SP or memory activity.
//     undefined : no comparators, fault is constant 0.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   req_valid/ready    request handshake (ready only while IDLE)
//   req_op, req_data   opcode (stack_pkg::op_e) and PUSH word / LOAD SP value
//   done               one-cycle pulse when an accepted request retires
//   rsp_data           POP result, valid with done on a POP
//   fault              one-cycle pulse with done on overflow/underflow
//   sp_value           current SP (direct output of the SP register)
//   sp_oe_a            SP drives the address bus
//   sp_ld, sp_in       SP load strobe and load value
//   sp_pre_dec         SP decrement strobe (before a PUSH write)
//   sp_post_inc        SP increment strobe (after a POP read)
//   mem_req/we/wdata   memory request, held until mem_ack
//   mem_rdata, mem_ack memory read data and completion
//
// Timing
//   All outputs are registered and decoded from the next state, so they
//   change only at clock edges (or asynchronously on rst).
//   Counting the accept cycle as cycle 0:
//     LOAD : sp_ld + done in cycle 1
//     POP  : mem_req from cycle 1; post_inc + done in the cycle after mem_ack
//     PUSH : pre_dec in cycle 1, mem_req from cycle 2; done is registered off
//            mem_ack, so it appears in the cycle after the ack, which is also
//            the first IDLE cycle (back-to-back PUSHes every 3rd cycle).
// -----------------------------------------------------------------------------
module stack_seq
    import stack_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] STACK_BASE  = WIDTH'(DEFAULT_STACK_BASE),
    parameter logic [WIDTH-1:0] STACK_LIMIT = WIDTH'(DEFAULT_STACK_LIMIT)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic             done,
    output logic [WIDTH-1:0] rsp_data,
    output logic             fault,

    input  logic [WIDTH-1:0] sp_value,
    output logic             sp_oe_a,
    output logic             sp_ld,
    output logic [WIDTH-1:0] sp_in,
    output logic             sp_pre_dec,
    output logic             sp_post_inc,

    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_e           state_reg;
    state_e           state_next;

    logic             req_ready_reg;
    logic             done_reg;
    logic             done_next;
    logic             fault_reg;
    logic             fault_next;
    logic [WIDTH-1:0] rsp_data_reg;
    logic             sp_oe_a_reg;
    logic             sp_ld_reg;
    logic [WIDTH-1:0] sp_in_reg;
    logic             sp_pre_dec_reg;
    logic             sp_post_inc_reg;
    logic             mem_req_reg;
    logic             mem_we_reg;
    logic [WIDTH-1:0] mem_wdata_reg;

    // -------------------------------------------------------------------------
    // Stack bounds detection (sampled against SP at the accept cycle)
    // -------------------------------------------------------------------------
    logic push_blocked;
    logic pop_blocked;

`ifdef STACK_BOUNDS_CHECK_EN
    assign push_blocked = (sp_value == STACK_LIMIT);
    assign pop_blocked  = (sp_value == STACK_BASE);
`else
    assign push_blocked = 1'b0;
    assign pop_blocked  = 1'b0;

    // SP value and stack geometry only feed the bounds comparators.
    logic unused_bounds;
    assign unused_bounds = ^{sp_value, STACK_BASE, STACK_LIMIT};
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        fault_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // req_ready is high exactly when the FSM is idle, so a valid
                // request seen here is an accepted request.
                if (req_valid) begin
                    case (op_e'(req_op))
                        OP_PUSH: begin
                            if (push_blocked) begin
                                done_next  = 1'b1;
                                fault_next = 1'b1;
                            end else begin
                                state_next = S_PUSH_DEC;
                            end
                        end
                        OP_POP: begin
                            if (pop_blocked) begin
                                done_next  = 1'b1;
                                fault_next = 1'b1;
                            end else begin
                                state_next = S_POP_RD;
                            end
                        end
                        OP_LOAD: begin
                            state_next = S_LOAD;
                        end
                        default: begin
                            // Undefined opcode: retire next cycle, no effects.
                            done_next = 1'b1;
                        end
                    endcase
                end
            end

            S_PUSH_DEC: begin
                state_next = S_PUSH_WR;
            end

            S_PUSH_WR: begin
                if (mem_ack) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end
            end

            S_POP_RD: begin
                if (mem_ack) begin
                    state_next = S_POP_INC;
                end
            end

            S_POP_INC: begin
                state_next = S_IDLE;
            end

            S_LOAD: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // POP and LOAD retire in the same cycle as their SP strobe.
        if ((state_next == S_POP_INC) || (state_next == S_LOAD)) begin
            done_next = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State register and output registers. Outputs are decoded from
    // state_next so they line up with the state they belong to.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            req_ready_reg   <= 1'b1;
            done_reg        <= 1'b0;
            fault_reg       <= 1'b0;
            rsp_data_reg    <= '0;
            sp_oe_a_reg     <= 1'b0;
            sp_ld_reg       <= 1'b0;
            sp_in_reg       <= '0;
            sp_pre_dec_reg  <= 1'b0;
            sp_post_inc_reg <= 1'b0;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_wdata_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            req_ready_reg   <= (state_next == S_IDLE);
            done_reg        <= done_next;
            fault_reg       <= fault_next;
            sp_oe_a_reg     <= drives_mem(state_next);
            mem_req_reg     <= drives_mem(state_next);
            mem_we_reg      <= (state_next == S_PUSH_WR);
            sp_pre_dec_reg  <= (state_next == S_PUSH_DEC);
            sp_post_inc_reg <= (state_next == S_POP_INC);
            sp_ld_reg       <= (state_next == S_LOAD);

            // Capture request data only for ops that will actually use it,
            // so a faulted PUSH leaves the write-data bus untouched.
            if ((state_reg == S_IDLE) && (state_next == S_PUSH_DEC)) begin
                mem_wdata_reg <= req_data;
            end
            if ((state_reg == S_IDLE) && (state_next == S_LOAD)) begin
                sp_in_reg <= req_data;
            end

            if ((state_reg == S_POP_RD) && mem_ack) begin
                rsp_data_reg <= mem_rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output assignments
    // -------------------------------------------------------------------------
    assign req_ready   = req_ready_reg;
    assign done        = done_reg;
    assign fault       = fault_reg;
    assign rsp_data    = rsp_data_reg;
    assign sp_oe_a     = sp_oe_a_reg;
    assign sp_ld       = sp_ld_reg;
    assign sp_in       = sp_in_reg;
    assign sp_pre_dec  = sp_pre_dec_reg;
    assign sp_post_inc = sp_post_inc_reg;
    assign mem_req     = mem_req_reg;
    assign mem_we      = mem_we_reg;
    assign mem_wdata   = mem_wdata_reg;

endmodule
